// File: rtl/axis_packet_fifo.sv
// rtl/axis_packet_fifo.sv - AXI-stream FIFO with tlast propagation and optional store-and-forward gating
module axis_packet_fifo #(
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DWIDTH-1:0]        s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [DWIDTH-1:0]        m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [$clog2(DEPTH):0]   packet_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DWIDTH:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            in_pkt;

  logic            wr;
  logic            rd;
  logic            out_free;
  logic            from_mem;
  logic            escape;
  logic            gate_ok;
  logic            load;
  logic            bypass;
  logic [CW-1:0]   mem_cnt;
  logic [CW-1:0]   pkt_in_mem;
  logic [CW-1:0]   occ_next;
  logic [DWIDTH:0] src;

  // The output register is part of occupancy; mem_cnt/pkt_in_mem describe only the RAM behind it.
  always_comb begin
    wr         = s_valid & s_ready;
    rd         = m_valid & m_ready;
    mem_cnt    = occupancy - CW'(m_valid);
    pkt_in_mem = packet_count - CW'(m_valid & m_last);
    escape     = (occupancy == FULL) && (packet_count == '0);
    // A new packet may start only once its last word is stored or arriving now.
    gate_ok    = (PACKET_MODE == 0) || in_pkt || (pkt_in_mem != '0) || (wr && s_last) || escape;
    from_mem   = (mem_cnt != '0);
    out_free   = !m_valid || m_ready;
    load       = out_free && (from_mem || wr) && gate_ok;
    bypass     = load && !from_mem;
    src        = from_mem ? mem[rd_ptr] : {s_last, s_data};
    occ_next   = occupancy + CW'(wr) - CW'(rd);
  end

  always_ff @(posedge clk) begin
    if (wr && !bypass) begin
      mem[wr_ptr] <= {s_last, s_data};
    end
    if (load) begin
      m_data <= src[DWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      packet_count <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      s_ready      <= 1'b0;
      in_pkt       <= 1'b0;
    end else begin
      if (wr && !bypass) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load && from_mem) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (load) begin
        m_valid <= 1'b1;
        m_last  <= src[DWIDTH];
        in_pkt  <= !src[DWIDTH];
      end else if (rd) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      occupancy    <= occ_next;
      packet_count <= packet_count + CW'(wr && s_last) - CW'(rd && m_last);
      s_ready      <= (occ_next < FULL);
      assert (!(wr && occupancy == FULL));
      assert (!(rd && occupancy == '0));
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb/tb_axis_packet_fifo.sv - directed self-checking bench for axis_packet_fifo in both packet modes
module tb_axis_packet_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        m_ready;

  logic        s_ready0, m_valid0, m_last0;
  logic [31:0] m_data0;
  logic [4:0]  occupancy0, packet_count0;
  logic        s_ready1, m_valid1, m_last1;
  logic [31:0] m_data1;
  logic [4:0]  occupancy1, packet_count1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_packet_fifo #(.DWIDTH(32), .DEPTH(16), .PACKET_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready),
    .occupancy(occupancy0), .packet_count(packet_count0)
  );

  axis_packet_fifo #(.DWIDTH(32), .DEPTH(16), .PACKET_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready),
    .occupancy(occupancy1), .packet_count(packet_count1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  logic [32:0] words [1000];

  initial begin
    int acc;
    int tx;
    int rx;
    int first_tx;
    int len;
    int n;
    logic occ_over;

    reset_n = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    tick();
    tick();
    chk("rst_m_valid", 64'(m_valid0), 64'(0));
    chk("rst_m_last", 64'(m_last0), 64'(0));
    chk("rst_s_ready", 64'(s_ready0), 64'(0));
    chk("rst_occ", 64'(occupancy0), 64'(0));
    chk("rst_pcnt", 64'(packet_count0), 64'(0));
    chk("rst_m_valid_pm", 64'(m_valid1), 64'(0));
    reset_n = 1'b1;
    tick();
    chk("rst_s_ready_up", 64'(s_ready0), 64'(1));

    // cut-through single word
    s_data = 32'hA5; s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1;
    tick();
    chk("ct_out", 64'({m_valid0, m_last0, m_data0}), 64'({1'b1, 1'b1, 32'hA5}));
    chk("ct_occ1", 64'(occupancy0), 64'(1));
    chk("ct_pcnt1", 64'(packet_count0), 64'(1));
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    chk("ct_drained", 64'(m_valid0), 64'(0));
    chk("ct_occ0", 64'(occupancy0), 64'(0));
    chk("ct_pcnt0", 64'(packet_count0), 64'(0));

    // fill to full, then drain in order
    do_reset();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 32'(acc); s_last = 1'b0;
      if (s_ready0) acc++;
      tick();
    end
    chk("fill_accepted", 64'(acc), 64'(16));
    chk("fill_s_ready", 64'(s_ready0), 64'(0));
    chk("fill_occ", 64'(occupancy0), 64'(16));
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_word", 64'({m_valid0, m_last0, m_data0}), 64'({1'b1, 1'b0, 32'(k)}));
      tick();
      if (k == 0) chk("drain_s_ready", 64'(s_ready0), 64'(1));
    end
    chk("drain_empty", 64'(m_valid0), 64'(0));
    chk("drain_occ", 64'(occupancy0), 64'(0));

    // store-and-forward gating
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 32'h10 + 32'(i); s_last = (i == 4);
      tick();
      chk("sf_gate", 64'(m_valid1), 64'(i == 4));
    end
    chk("sf_pcnt1", 64'(packet_count1), 64'(1));
    s_valid = 1'b0; s_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("sf_word", 64'({m_valid1, m_last1, m_data1}), 64'({1'b1, (k == 4), 32'h10 + 32'(k)}));
      tick();
    end
    chk("sf_done", 64'(m_valid1), 64'(0));
    chk("sf_pcnt0", 64'(packet_count1), 64'(0));

    // deadlock escape with a 20-word packet
    do_reset();
    m_ready = 1'b1;
    tx = 0; rx = 0; first_tx = -1;
    for (int cyc = 0; cyc < 200 && rx < 20; cyc++) begin
      s_valid = (tx < 20); s_data = 32'h100 + 32'(tx); s_last = (tx == 19);
      if (m_valid1 && m_ready) begin
        if (first_tx < 0) first_tx = tx;
        chk("esc_word", 64'({m_last1, m_data1}), 64'({(rx == 19), 32'h100 + 32'(rx)}));
        rx++;
      end
      if (s_valid && s_ready1) tx++;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("esc_release_at", 64'(first_tx), 64'(16));
    chk("esc_count", 64'(rx), 64'(20));
    chk("esc_empty", 64'({m_valid1, occupancy1, packet_count1}), 64'(0));

    // random arrivals and backpressure against a scoreboard
    n = 0;
    while (n < 1000) begin
      len = $urandom_range(1, 40);
      for (int j = 0; j < len && n < 1000; j++) begin
        words[n] = {(j == len - 1) || (n == 999), $urandom()};
        n++;
      end
    end
    do_reset();
    tx = 0; rx = 0; occ_over = 1'b0;
    for (int cyc = 0; cyc < 20000 && rx < 1000; cyc++) begin
      s_valid = (tx < 1000) && ($urandom_range(0, 3) != 0);
      s_data  = words[tx < 1000 ? tx : 999][31:0];
      s_last  = words[tx < 1000 ? tx : 999][32];
      m_ready = ($urandom_range(0, 2) != 0);
      if (occupancy1 > 5'd16) occ_over = 1'b1;
      if (m_valid1) begin
        if ({m_last1, m_data1} !== words[rx]) chk("rnd_word", 64'({m_last1, m_data1}), 64'(words[rx]));
        if (m_ready) rx++;
      end
      if (s_valid && s_ready1) tx++;
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("rnd_count", 64'(rx), 64'(1000));
    chk("rnd_occ_bound", 64'(occ_over), 64'(0));

    // reset in the middle of a packet
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = 32'h300 + 32'(i); s_last = 1'b0;
      tick();
    end
    chk("mid_occ7", 64'(occupancy1), 64'(7));
    chk("mid_gated", 64'(m_valid1), 64'(0));
    reset_n = 1'b0; s_valid = 1'b0;
    tick();
    chk("mid_rst", 64'({m_valid1, occupancy1, packet_count1, s_ready1}), 64'(0));
    chk("mid_rst_ct", 64'({m_valid0, occupancy0}), 64'(0));
    reset_n = 1'b1;
    tick();
    chk("mid_ready", 64'(s_ready1), 64'(1));
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h400 + 32'(i); s_last = (i == 2);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_word", 64'({m_valid1, m_last1, m_data1}), 64'({1'b1, (k == 2), 32'h400 + 32'(k)}));
      tick();
    end
    tick();
    tick();
    chk("mid_no_stale", 64'({m_valid1, occupancy1, packet_count1}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
